// File: rtl/neuron_core_tick_scheduler.sv
// Wishbone master that sequences one SNN time-step on the neuron core: it replays queued
// axon events as synapse-row reads, then reads and clears the spike-out register.
module neuron_core_tick_scheduler #(
    parameter logic [31:0] SYNAPSE_BASE   = 32'h3000_0000,
    parameter logic [31:0] SPIKE_OUT_BASE = 32'h3000_8000,
    parameter int          FIFO_DEPTH     = 16,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        evt_valid_i,
    input  logic [7:0]  evt_axon_i,
    output logic        evt_ready_o,
    input  logic        tick_i,
    output logic        busy_o,
    output logic        spike_valid_o,
    output logic [31:0] spike_vec_o,
    output logic        done_o,
    output logic        err_timeout_o,
    output logic        err_overrun_o,
    output logic [7:0]  drop_cnt_o,
    input  logic        clr_err_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {S_IDLE, S_POP, S_ROW_RD, S_SPK_RD, S_SPK_CLR, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d, rem_q, rem_d;
    logic [1:0]     pop_ph_q, pop_ph_d;
    logic           wb_gap_q, wb_gap_d;
    logic [7:0]     tmo_q, tmo_d;
    logic [31:0]    adr_q, adr_d;
    logic [31:0]    spike_vec_q, spike_vec_d;
    logic           abort_q, abort_d;
    logic           err_tmo_q, err_tmo_d, err_ovr_q, err_ovr_d;
    logic [7:0]     drop_q, drop_d;

    logic [7:0]     mem [FIFO_DEPTH];
    logic [7:0]     ram_q;

    logic           full, push, pop, discard, wb_active;
    logic [7:0]     drop_base;

    assign full = (count_q == CW'(FIFO_DEPTH));
    assign push = evt_valid_i && !full;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= evt_axon_i;
        end
        ram_q <= mem[rd_ptr_q];
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q + (push ? PW'(1) : PW'(0));
        rd_ptr_d    = rd_ptr_q;
        rem_d       = rem_q;
        pop_ph_d    = pop_ph_q;
        wb_gap_d    = wb_gap_q;
        tmo_d       = tmo_q;
        adr_d       = adr_q;
        spike_vec_d = spike_vec_q;
        abort_d     = abort_q;
        err_tmo_d   = err_tmo_q && !clr_err_i;
        err_ovr_d   = err_ovr_q && !clr_err_i;
        pop         = 1'b0;
        discard     = 1'b0;
        wb_active   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tick_i) begin
                    rem_d    = count_q;
                    abort_d  = 1'b0;
                    pop_ph_d = 2'd0;
                    state_d  = (count_q == '0) ? S_SPK_RD : S_POP;
                end
            end
            // Pop, wait for the RAM output, register the row address, then one pad cycle so
            // every replayed axon costs a fixed six cycles with a zero-wait slave.
            S_POP: begin
                case (pop_ph_q)
                    2'd0: begin
                        pop      = 1'b1;
                        rd_ptr_d = rd_ptr_q + PW'(1);
                        rem_d    = rem_q - CW'(1);
                        pop_ph_d = 2'd1;
                    end
                    2'd1: begin
                        adr_d    = SYNAPSE_BASE + {22'd0, ram_q, 2'b00};
                        pop_ph_d = 2'd2;
                    end
                    default: begin
                        pop_ph_d = 2'd0;
                        state_d  = S_ROW_RD;
                    end
                endcase
            end
            S_ROW_RD, S_SPK_RD, S_SPK_CLR: begin
                if (!wb_gap_q) begin
                    wb_active = 1'b1;
                    tmo_d     = tmo_q + 8'd1;
                    if (wbm_ack_i) begin
                        wb_gap_d = 1'b1;
                        if (state_q == S_SPK_RD) begin
                            spike_vec_d = wbm_dat_i;
                        end
                    end else if (tmo_q == 8'(TIMEOUT_CYCLES - 1)) begin
                        // Abort: unreplayed snapshot entries are thrown away with the tick.
                        discard   = 1'b1;
                        rd_ptr_d  = rd_ptr_q + PW'(rem_q);
                        rem_d     = '0;
                        tmo_d     = 8'd0;
                        abort_d   = 1'b1;
                        err_tmo_d = 1'b1;
                        state_d   = S_DONE;
                    end
                end else begin
                    wb_gap_d = 1'b0;
                    tmo_d    = 8'd0;
                    case (state_q)
                        S_ROW_RD: state_d = (rem_q == '0) ? S_SPK_RD : S_POP;
                        S_SPK_RD: state_d = S_SPK_CLR;
                        default:  state_d = S_DONE;
                    endcase
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (tick_i && state_q != S_IDLE) begin
            err_ovr_d = 1'b1;
        end

        count_d   = count_q + CW'(push) - CW'(pop) - (discard ? rem_q : CW'(0));
        drop_base = clr_err_i ? 8'd0 : drop_q;
        drop_d    = (evt_valid_i && full && drop_base != 8'hFF) ? drop_base + 8'd1 : drop_base;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rem_q       <= '0;
            pop_ph_q    <= 2'd0;
            wb_gap_q    <= 1'b0;
            tmo_q       <= 8'd0;
            adr_q       <= 32'd0;
            spike_vec_q <= 32'd0;
            abort_q     <= 1'b0;
            err_tmo_q   <= 1'b0;
            err_ovr_q   <= 1'b0;
            drop_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            pop_ph_q    <= pop_ph_d;
            wb_gap_q    <= wb_gap_d;
            tmo_q       <= tmo_d;
            adr_q       <= adr_d;
            spike_vec_q <= spike_vec_d;
            abort_q     <= abort_d;
            err_tmo_q   <= err_tmo_d;
            err_ovr_q   <= err_ovr_d;
            drop_q      <= drop_d;
        end
    end

    assign evt_ready_o   = !full;
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);
    assign spike_valid_o = (state_q == S_DONE) && !abort_q;
    assign spike_vec_o   = spike_vec_q;
    assign err_timeout_o = err_tmo_q;
    assign err_overrun_o = err_ovr_q;
    assign drop_cnt_o    = drop_q;

    assign wbm_cyc_o = wb_active;
    assign wbm_stb_o = wb_active;
    assign wbm_we_o  = wb_active && (state_q == S_SPK_CLR);
    assign wbm_sel_o = 4'hF;
    assign wbm_adr_o = !wb_active ? 32'd0 : (state_q == S_ROW_RD) ? adr_q : SPIKE_OUT_BASE;
    assign wbm_dat_o = 32'd0;
endmodule

// File: tb/tb_neuron_core_tick_scheduler.sv
// Randomized bench for neuron_core_tick_scheduler: a queue-based event model plus a
// zero-wait Wishbone slave; every tick's bus traffic, latency and flags are checked.
module tb_neuron_core_tick_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        evt_valid_i, tick_i, clr_err_i, wbm_ack_i;
    logic [7:0]  evt_axon_i;
    logic        evt_ready_o, busy_o, spike_valid_o, done_o, err_timeout_o, err_overrun_o;
    logic [31:0] spike_vec_o, wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [7:0]  drop_cnt_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;

    neuron_core_tick_scheduler dut (
        .clk(clk), .rst(rst),
        .evt_valid_i(evt_valid_i), .evt_axon_i(evt_axon_i), .evt_ready_o(evt_ready_o),
        .tick_i(tick_i), .busy_o(busy_o), .spike_valid_o(spike_valid_o),
        .spike_vec_o(spike_vec_o), .done_o(done_o), .err_timeout_o(err_timeout_o),
        .err_overrun_o(err_overrun_o), .drop_cnt_o(drop_cnt_o), .clr_err_i(clr_err_i),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Zero-wait slave: ack one cycle after stb, suppressed while hang is set.
    logic        hang = 1'b0;
    logic [31:0] spk_val = 32'd0;
    assign wbm_dat_i = spk_val;
    always @(posedge clk or posedge rst) begin
        if (rst) wbm_ack_i <= 1'b0;
        else     wbm_ack_i <= wbm_cyc_o && wbm_stb_o && !wbm_ack_i && !hang;
    end

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt++;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        logic [3:0]  sel;
    } txn_t;
    txn_t log_q[$];
    int   run_len = 0, last_run = 0, gap_viol = 0;
    logic prev_ack = 1'b0;

    always @(negedge clk) begin
        if (wbm_cyc_o && wbm_stb_o && wbm_ack_i)
            log_q.push_back('{wbm_adr_o, wbm_we_o, wbm_dat_o, wbm_sel_o});
        if (prev_ack && wbm_cyc_o) gap_viol++;
        prev_ack = wbm_cyc_o && wbm_ack_i;
        if (wbm_cyc_o) run_len++;
        else begin
            if (run_len > 0) last_run = run_len;
            run_len = 0;
        end
    end

    // Reference model
    int          mq[$];
    int          mdrop = 0;
    bit          movr = 0, mtmo = 0;
    logic [31:0] last_spk = 32'd0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ax, input bit do_chk);
        evt_valid_i = 1'b1;
        evt_axon_i  = ax[7:0];
        if (do_chk) check_val("evt_ready", {31'd0, evt_ready_o}, (mq.size() < 16) ? 1 : 0);
        if (mq.size() < 16) mq.push_back(ax & 255);
        else if (mdrop < 255) mdrop++;
        step();
        evt_valid_i = 1'b0;
    endtask

    task automatic clear_errors();
        clr_err_i = 1'b1;
        step();
        clr_err_i = 1'b0;
        mdrop = 0; movr = 0; mtmo = 0;
        check_val("clr_drop", {24'd0, drop_cnt_o}, 0);
        check_val("clr_ovr", {31'd0, err_overrun_o}, 0);
        check_val("clr_tmo", {31'd0, err_timeout_o}, 0);
    endtask

    task automatic run_tick(input bit hang_mode, input bit overrun, input logic [31:0] spk);
        int n, t0;
        int exp_ax[$];
        bit seen;
        n = mq.size();
        for (int i = 0; i < n; i++) exp_ax.push_back(mq[i]);
        spk_val = spk;
        hang    = hang_mode;
        log_q.delete();
        tick_i = 1'b1;
        t0 = cyc_cnt;
        step();
        tick_i = 1'b0;
        check_val("busy_start", {31'd0, busy_o}, 1);
        if (overrun) begin
            repeat (3) step();
            // Second tick mid-replay, with a simultaneous clear: the set must win.
            tick_i = 1'b1; clr_err_i = 1'b1;
            movr = 1; mdrop = 0; mtmo = 0;
            step();
            tick_i = 1'b0; clr_err_i = 1'b0;
            push($urandom_range(0, 255), 1);
            push($urandom_range(0, 255), 1);
        end
        seen = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (done_o) seen = 1;
        end
        check_val("done_seen", {31'd0, seen}, 1);
        if (seen) begin
            if (!hang_mode) check_val("latency", cyc_cnt - t0, 6 * n + 7);
            check_val("spike_valid", {31'd0, spike_valid_o}, hang_mode ? 0 : 1);
            if (!hang_mode) last_spk = spk;
            check_val("spike_vec", spike_vec_o, last_spk);
            check_val("cyc_at_done", {31'd0, wbm_cyc_o}, 0);
        end
        @(negedge clk);
        check_val("done_pulse", {31'd0, done_o}, 0);
        check_val("valid_pulse", {31'd0, spike_valid_o}, 0);
        check_val("busy_end", {31'd0, busy_o}, 0);
        if (hang_mode) begin
            mtmo = 1;
            check_val("tmo_cycles", last_run, 255);
            check_val("tmo_log_len", log_q.size(), 0);
        end else begin
            check_val("log_len", log_q.size(), n + 2);
            if (log_q.size() == n + 2) begin
                for (int i = 0; i < n; i++) begin
                    check_val("row_adr", log_q[i].adr, 32'h3000_0000 + exp_ax[i] * 4);
                    check_val("row_we", {31'd0, log_q[i].we}, 0);
                end
                check_val("spk_rd_adr", log_q[n].adr, 32'h3000_8000);
                check_val("spk_rd_we", {31'd0, log_q[n].we}, 0);
                check_val("spk_clr_adr", log_q[n+1].adr, 32'h3000_8000);
                check_val("spk_clr_we", {31'd0, log_q[n+1].we}, 1);
                check_val("spk_clr_dat", log_q[n+1].dat, 0);
                check_val("spk_clr_sel", {28'd0, log_q[n+1].sel}, 32'hF);
            end
        end
        for (int i = 0; i < n; i++) void'(mq.pop_front());
        check_val("err_timeout", {31'd0, err_timeout_o}, {31'd0, mtmo});
        check_val("err_overrun", {31'd0, err_overrun_o}, {31'd0, movr});
        check_val("drop_cnt", {24'd0, drop_cnt_o}, mdrop);
        hang = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit got;
        rst = 1'b1; evt_valid_i = 1'b0; evt_axon_i = 8'd0; tick_i = 1'b0; clr_err_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_ready", {31'd0, evt_ready_o}, 1);
        check_val("rst_busy", {31'd0, busy_o}, 0);
        check_val("rst_cyc", {31'd0, wbm_cyc_o}, 0);
        check_val("rst_stb", {31'd0, wbm_stb_o}, 0);
        check_val("rst_done", {31'd0, done_o}, 0);
        check_val("rst_valid", {31'd0, spike_valid_o}, 0);
        check_val("rst_vec", spike_vec_o, 0);
        check_val("rst_errs", {30'd0, err_timeout_o, err_overrun_o}, 0);
        check_val("rst_drop", {24'd0, drop_cnt_o}, 0);
        step();

        // Directed: two axons, then an empty tick.
        push(3, 1);
        push(200, 1);
        repeat (2) step();
        run_tick(0, 0, 32'h8000_0001);
        run_tick(0, 0, $urandom);

        // Overfill: 20 pushes into 16 entries.
        for (int i = 0; i < 20; i++) push($urandom_range(0, 255), 1);
        check_val("drop_after_20", {24'd0, drop_cnt_o}, mdrop);
        run_tick(0, 0, $urandom);

        // Overrun during replay; mid-tick pushes are replayed by the following tick.
        for (int i = 0; i < 3; i++) push($urandom_range(0, 255), 1);
        run_tick(0, 1, $urandom);
        check_val("mid_push_kept", mq.size(), 2);
        run_tick(0, 0, $urandom);
        clear_errors();

        // Timeout on the first row read, then an empty follow-up tick.
        for (int i = 0; i < 5; i++) push($urandom_range(0, 255), 1);
        run_tick(1, 0, $urandom);
        check_val("tmo_ready", {31'd0, evt_ready_o}, 1);
        run_tick(0, 0, $urandom);
        clear_errors();

        // Drop counter saturation.
        for (int i = 0; i < 280; i++) push($urandom_range(0, 255), 0);
        check_val("drop_sat", {24'd0, drop_cnt_o}, 255);
        check_val("full_ready", {31'd0, evt_ready_o}, 0);
        run_tick(0, 0, $urandom);
        clear_errors();

        // Asynchronous reset while strobing.
        for (int i = 0; i < 4; i++) push($urandom_range(0, 255), 1);
        spk_val = $urandom;
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (wbm_stb_o) got = 1;
        end
        check_val("stb_seen", {31'd0, got}, 1);
        rst = 1'b1;
        #1;
        check_val("arst_cyc", {31'd0, wbm_cyc_o}, 0);
        check_val("arst_stb", {31'd0, wbm_stb_o}, 0);
        check_val("arst_ready", {31'd0, evt_ready_o}, 1);
        check_val("arst_busy", {31'd0, busy_o}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete(); mdrop = 0; movr = 0; mtmo = 0; last_spk = 32'd0;
        check_val("arst_vec", spike_vec_o, 0);
        step();
        push($urandom_range(0, 255), 1);
        push($urandom_range(0, 255), 1);
        run_tick(0, 0, $urandom);

        // Randomized rounds.
        for (int r = 0; r < 8; r++) begin
            int k;
            k = $urandom_range(0, 18);
            for (int i = 0; i < k; i++) begin
                push($urandom_range(0, 255), 1);
                if ($urandom_range(0, 3) == 0) step();
            end
            repeat ($urandom_range(0, 3)) step();
            run_tick(0, 0, $urandom);
        end

        check_val("wb_gap", gap_viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
